wave_seq_ctrl: RTL and testbench

Sequencer that feeds the wave-word DAC controller with a stream of 32-bit wave words from a synchronous wave table. It fetches words starting at a programmed base address, issues each one to the DAC controller with a single-cycle request, waits for that word to complete, and advances until a terminator word (samples field = 0) ends the pass. The table can be replayed a programmed number of times. Voltage and slope fault flags from the DAC controller are collected and reported.

---
 rtl/wave_seq_ctrl.sv | 153 +++++++++++++++
 tb/tb_wave_seq_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wave_seq_ctrl.sv
// Wave-table sequencer: fetches 32-bit wave words from a synchronous table and hands them one at a time to the DAC controller.
// Optional build macro WAVE_SEQ_ERR_ABORT_EN: a word completing with a recorded fault ends the run with an err_abort pulse.
module wave_seq_ctrl #(
  parameter int ADDR_W = 8,
  parameter int LOOP_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LOOP_W-1:0] loop_cnt,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              ww_req,
  output logic [31:0]       ww_word,
  input  logic              ww_done,
  input  logic              wave_done,
  input  logic              volmax_err,
  input  logic              slope_err,
  output logic              busy,
  output logic              seq_done,
  output logic              err_abort,
  output logic [1:0]        err_code,
  output logic [15:0]       word_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, base;
  logic [LOOP_W-1:0] loops_left;
  logic              stop_pend;
  logic [1:0]        err_nxt;
  logic              ld_start, addr_inc, addr_rewind, loop_dec, done_nat;
`ifdef WAVE_SEQ_ERR_ABORT_EN
  logic              go_abort;
`endif

  // The current address register doubles as the registered read address.
  assign mem_addr = addr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ld_start    = 1'b0;
    addr_inc    = 1'b0;
    addr_rewind = 1'b0;
    loop_dec    = 1'b0;
    done_nat    = 1'b0;
`ifdef WAVE_SEQ_ERR_ABORT_EN
    go_abort    = 1'b0;
`endif
    err_nxt = err_code;
    if (state == S_WAIT) err_nxt = err_code | {slope_err, volmax_err};

    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          ld_start  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_LATCH;
      S_LATCH: state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (ww_done) begin
          // A stop arriving together with ww_done counts as pending.
          if (stop_pend || stop) begin
            state_nxt = S_IDLE;
`ifdef WAVE_SEQ_ERR_ABORT_EN
          end else if (err_nxt != 2'b00) begin
            state_nxt = S_IDLE;
            go_abort  = 1'b1;
`endif
          end else if (wave_done && loops_left == LOOP_W'(1)) begin
            state_nxt = S_IDLE;
            done_nat  = 1'b1;
          end else if (wave_done) begin
            state_nxt   = S_FETCH;
            addr_rewind = 1'b1;
            loop_dec    = (loops_left != '0);
          end else begin
            state_nxt = S_FETCH;
            addr_inc  = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr       <= '0;
      base       <= '0;
      loops_left <= '0;
      stop_pend  <= 1'b0;
      mem_rd     <= 1'b0;
      ww_req     <= 1'b0;
      ww_word    <= '0;
      busy       <= 1'b0;
      seq_done   <= 1'b0;
      err_code   <= 2'b00;
      word_cnt   <= '0;
    end else begin
      mem_rd   <= (state_nxt == S_FETCH);
      ww_req   <= (state_nxt == S_ISSUE);
      busy     <= (state_nxt != S_IDLE);
      seq_done <= done_nat;
      err_code <= ld_start ? 2'b00 : err_nxt;

      if (ld_start) begin
        addr       <= base_addr;
        base       <= base_addr;
        loops_left <= loop_cnt;
        word_cnt   <= '0;
      end else begin
        if (addr_inc)    addr <= addr + ADDR_W'(1);
        if (addr_rewind) addr <= base;
        if (loop_dec)    loops_left <= loops_left - LOOP_W'(1);
        if (state == S_ISSUE && word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
      end

      if (state == S_LATCH) ww_word <= mem_rdata;

      if (state_nxt == S_IDLE) stop_pend <= 1'b0;
      else if (stop)           stop_pend <= 1'b1;
    end
  end

`ifdef WAVE_SEQ_ERR_ABORT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_abort <= 1'b0;
    else       err_abort <= go_abort;
  end
`else
  assign err_abort = 1'b0;
`endif

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Self-checking bench for wave_seq_ctrl: table vectors, random runs against a pass/address model, and hand-written corner sequences.
module tb_wave_seq_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, stop;
  logic [7:0]  base_addr, loop_cnt;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        ww_req;
  logic [31:0] ww_word;
  logic        ww_done, wave_done;
  logic        volmax_err, slope_err;
  logic        busy, seq_done, err_abort;
  logic [1:0]  err_code;
  logic [15:0] word_cnt;

  wave_seq_ctrl #(.ADDR_W(8), .LOOP_W(8)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop),
    .base_addr(base_addr), .loop_cnt(loop_cnt),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .ww_req(ww_req), .ww_word(ww_word), .ww_done(ww_done), .wave_done(wave_done),
    .volmax_err(volmax_err), .slope_err(slope_err),
    .busy(busy), .seq_done(seq_done), .err_abort(err_abort),
    .err_code(err_code), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous wave table: data valid the cycle after mem_rd.
  logic [31:0] mem [256];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  int n_chk = 0, n_pass = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // DAC controller stand-in: answers each request after dac_dly cycles (0 = random 1..6).
  int dac_dly = 0, done_cyc = -100, stab_bad = 0;
  initial begin
    int d;
    bit ab;
    logic [31:0] w;
    ww_done = 1'b0;
    wave_done = 1'b0;
    forever begin
      @(negedge clk);
      ww_done = 1'b0;
      wave_done = 1'b0;
      if (rstn && ww_req) begin
        w = ww_word;
        d = (dac_dly == 0) ? int'($urandom_range(1, 6)) : dac_dly;
        ab = 1'b0;
        repeat (d) begin
          @(negedge clk);
          if (!rstn) ab = 1'b1;
          else if (!ab && ww_word !== w) stab_bad++;
        end
        if (!ab) begin
          ww_done = 1'b1;
          wave_done = (w[7:0] == 8'h00);
          done_cyc = cyc;
        end
      end
    end
  end

  // Monitor: records every request and checks request timing relative to start and ww_done.
  logic [7:0]  req_addr[$];
  logic [31:0] req_word[$];
  int mem_rd_cnt = 0, sd_cnt = 0, ab_cnt = 0, sd_cyc = -100;
  int lat_bad = 0, space_bad = 0, rise_cyc = 0, last_req = -100;
  bit busy_q = 1'b0, first_req = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      if (mem_rd) mem_rd_cnt++;
      if (seq_done) begin sd_cnt++; sd_cyc = cyc; end
      if (err_abort) ab_cnt++;
      if (busy && !busy_q) begin first_req = 1'b1; rise_cyc = cyc; end
      if (ww_req) begin
        req_addr.push_back(mem_addr);
        req_word.push_back(ww_word);
        if (first_req) begin
          if (cyc - rise_cyc != 2) lat_bad++;
          first_req = 1'b0;
        end else if (cyc - done_cyc != 3) lat_bad++;
        if (cyc - last_req < 4) space_bad++;
        last_req = cyc;
      end
      busy_q = busy;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic fill_table(input logic [7:0] b, input int ndata, input bit rnd);
    for (int i = 0; i < 256; i++) mem[i] = {24'(i), 8'h5A};
    for (int i = 0; i < ndata; i++)
      mem[8'(b + i)] = rnd ? {24'($urandom), 8'($urandom_range(1, 255))} : 32'(4 - i);
    mem[8'(b + ndata)] = rnd ? {24'($urandom), 8'h00} : 32'h0;
  endtask

  int fall_cyc = 0;
  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy) begin ok = 1'b1; fall_cyc = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [7:0] b, input logic [7:0] l);
    @(negedge clk);
    base_addr = b; loop_cnt = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Model: each pass issues base, base+1, ... up to the terminator, addresses modulo 256.
  task automatic check_run(input string name, input int q0, input logic [7:0] b, input int ndata, input int loops);
    int exp_n, bad;
    logic [7:0] ea;
    exp_n = (ndata + 1) * loops;
    bad = 0;
    check({name, "_nreq"}, req_addr.size() - q0, exp_n);
    for (int k = 0; k < exp_n && q0 + k < req_addr.size(); k++) begin
      ea = 8'(b + (k % (ndata + 1)));
      if (req_addr[q0 + k] !== ea || req_word[q0 + k] !== mem[ea]) bad++;
    end
    check({name, "_seq"}, bad, 0);
  endtask

  typedef struct {
    logic [7:0] base;
    logic [7:0] loops;
    int         ndata;
    int         exp_words;
    logic [7:0] exp_last;
  } vec_t;

  initial begin
    vec_t vecs[4];
    int q0, sd0, ab0, mr0, cnt, bad, nd, lp;
    bit ok, got;
    logic [7:0] b;

    vecs[0] = '{8'h10, 8'd1, 2, 3, 8'h12};
    vecs[1] = '{8'hFF, 8'd1, 1, 2, 8'h00};
    vecs[2] = '{8'h40, 8'd3, 1, 6, 8'h41};
    vecs[3] = '{8'hFE, 8'd2, 3, 8, 8'h01};

    rstn = 1'b0; start = 1'b0; stop = 1'b0; base_addr = '0; loop_cnt = '0;
    volmax_err = 1'b0; slope_err = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctl", {mem_rd, ww_req, busy, seq_done, err_abort, err_code}, 0);
    check("reset_data", {mem_addr, ww_word, word_cnt}, 0);
    rstn = 1'b1;
    @(negedge clk);

    dac_dly = 2;
    for (int v = 0; v < 4; v++) begin
      fill_table(vecs[v].base, vecs[v].ndata, 1'b0);
      q0 = req_addr.size(); sd0 = sd_cnt;
      pulse_start(vecs[v].base, vecs[v].loops);
      wait_idle(2000, ok);
      check("vec_done", ok, 1);
      check("vec_word_cnt", word_cnt, vecs[v].exp_words);
      check("vec_last_addr", mem_addr, vecs[v].exp_last);
      check("vec_seq_done", sd_cnt - sd0, 1);
      check("vec_seq_done_lat", sd_cyc, done_cyc + 1);
      check("vec_busy_fall", fall_cyc, done_cyc + 1);
      check_run("vec", q0, vecs[v].base, vecs[v].ndata, vecs[v].loops);
    end

    // start and stop together: stop wins
    @(negedge clk);
    base_addr = 8'h33; loop_cnt = 8'd1; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 0);
    check("startstop_mem_rd", mem_rd, 0);

    // Fault in WAIT of word 0
    dac_dly = 4;
    fill_table(8'h20, 2, 1'b0);
    q0 = req_addr.size(); sd0 = sd_cnt; ab0 = ab_cnt;
    pulse_start(8'h20, 8'd1);
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ww_req) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("err_first_req", got, 1);
    @(negedge clk); volmax_err = 1'b1;
    @(negedge clk); volmax_err = 1'b0;
    wait_idle(500, ok);
    check("err_idle", ok, 1);
    check("err_code", err_code, 2'b01);
`ifdef WAVE_SEQ_ERR_ABORT_EN
    check("err_abort_pulse", ab_cnt - ab0, 1);
    check("err_no_seq_done", sd_cnt - sd0, 0);
    check("err_nreq", req_addr.size() - q0, 1);
`else
    check("err_no_abort", ab_cnt - ab0, 0);
    check("err_seq_done", sd_cnt - sd0, 1);
    check("err_nreq", req_addr.size() - q0, 3);
`endif

    // Random runs; err_code must also clear on each new start
    for (int r = 0; r < 8; r++) begin
      b = 8'($urandom); nd = $urandom_range(0, 4); lp = $urandom_range(1, 3);
      fill_table(b, nd, 1'b1);
      dac_dly = 0;
      q0 = req_addr.size(); sd0 = sd_cnt;
      pulse_start(b, 8'(lp));
      wait_idle(3000, ok);
      check("rnd_done", ok, 1);
      check("rnd_word_cnt", word_cnt, (nd + 1) * lp);
      check("rnd_err_code", err_code, 0);
      check("rnd_seq_done", sd_cnt - sd0, 1);
      check_run("rnd", q0, b, nd, lp);
    end

    // Stop two cycles after the request of word 1
    dac_dly = 4;
    fill_table(8'h08, 3, 1'b0);
    q0 = req_addr.size(); sd0 = sd_cnt; mr0 = mem_rd_cnt;
    pulse_start(8'h08, 8'd1);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (ww_req) begin cnt++; if (cnt == 2) break; end
      @(negedge clk);
    end
    check("stop_req1_seen", cnt, 2);
    @(negedge clk);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_idle(200, ok);
    check("stop_idle", ok, 1);
    check("stop_busy_lat", fall_cyc, done_cyc + 1);
    repeat (10) @(negedge clk);
    check("stop_mem_rd_total", mem_rd_cnt - mr0, 2);
    check("stop_nreq", req_addr.size() - q0, 2);
    check("stop_no_seq_done", sd_cnt - sd0, 0);
    check("stop_word_cnt", word_cnt, 2);

    // Infinite looping: loop_cnt=0 still running after 20 passes
    dac_dly = 1;
    fill_table(8'h30, 1, 1'b0);
    q0 = req_addr.size(); sd0 = sd_cnt;
    pulse_start(8'h30, 8'd0);
    cnt = 0;
    for (int i = 0; i < 2000 && cnt < 42; i++) begin
      @(negedge clk);
      if (ww_req) cnt++;
    end
    check("inf_reqs", cnt, 42);
    check("inf_busy", busy, 1);
    check("inf_no_seq_done", sd_cnt - sd0, 0);
    bad = 0;
    for (int k = 0; k < 42 && q0 + k < req_addr.size(); k++)
      if (req_addr[q0 + k] !== 8'(8'h30 + (k % 2))) bad++;
    check("inf_addr_seq", bad, 0);
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    wait_idle(200, ok);
    check("inf_stop_idle", ok, 1);
    check("inf_stop_no_seq_done", sd_cnt - sd0, 0);

    // Asynchronous reset during WAIT, then a fresh run at a new base
    dac_dly = 5;
    fill_table(8'h50, 3, 1'b0);
    pulse_start(8'h50, 8'd1);
    for (int i = 0; i < 20; i++) begin
      if (ww_req) break;
      @(negedge clk);
    end
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("rst_async_ctl", {mem_rd, ww_req, busy, seq_done, err_abort, err_code}, 0);
    check("rst_async_data", {mem_addr, ww_word, word_cnt}, 0);
    @(negedge clk);
    @(negedge clk); rstn = 1'b1;
    repeat (10) @(negedge clk);
    fill_table(8'h60, 2, 1'b0);
    q0 = req_addr.size(); sd0 = sd_cnt;
    pulse_start(8'h60, 8'd1);
    wait_idle(500, ok);
    check("rst_rerun_done", ok, 1);
    check("rst_rerun_word_cnt", word_cnt, 3);
    check("rst_rerun_seq_done", sd_cnt - sd0, 1);
    check_run("rst_rerun", q0, 8'h60, 2, 1);

    check("ww_word_stable", stab_bad, 0);
    check("req_timing", lat_bad, 0);
    check("req_spacing", space_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
